sram_controller: RTL and testbench

- Bus slave that turns one 32-bit bus read or write into timed strobes on one asynchronous 32-bit SRAM chip. It sits directly downstream of the address decoder on the bus interconnect, on the RAM_ADDRESS_PREFIX (8'h00) region.
- A read fetches two consecutive words: the addressed word goes on bus_data_rd and the next word goes on bus_data_rd_2, for dual-word instruction fetch.
- Writes honour the 4-bit byte mask.
- The master is held with bus_stall until the access completes.

---
 rtl/sram_controller_if.sv | 22 ++
 rtl/sram_controller.sv | 148 ++++++++++++++
 tb/tb_sram_controller.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_if.sv
// Bus-side handshake of the SRAM controller: one read or write per request,
// held by the master while bus_stall is high, with two read-data words returned.
interface sram_controller_if;
  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_data_wr;
  logic [3:0]  bus_mask;
  logic        bus_stall;
  logic [31:0] bus_data_rd;
  logic [31:0] bus_data_rd_2;

  modport master (
    output bus_address, bus_read, bus_write, bus_data_wr, bus_mask,
    input  bus_stall, bus_data_rd, bus_data_rd_2
  );

  modport slave (
    input  bus_address, bus_read, bus_write, bus_data_wr, bus_mask,
    output bus_stall, bus_data_rd, bus_data_rd_2
  );
endinterface

// File: rtl/sram_controller.sv
// SRAM controller: turns a single bus read (two consecutive words) or a
// byte-masked bus write into timed strobes on an asynchronous 32-bit SRAM.
// Every SRAM-side output is registered, so no bus input reaches the chip
// pins combinationally.
module sram_controller #(
  parameter int WAIT_CYCLES     = 1,
  parameter int SRAM_ADDR_WIDTH = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  sram_controller_if.slave           bus,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_address,
  inout  wire  [31:0]                sram_data,
  output logic [3:0]                 sram_be_n,
  output logic                       sram_ce_n,
  output logic                       sram_oe_n,
  output logic                       sram_we_n
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, WR, WR_REC, DONE} state_t;

  localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES - 1);

  state_t                     r_state;
  logic [3:0]                 r_waitCnt;
  logic [SRAM_ADDR_WIDTH-1:0] r_addr;
  logic [SRAM_ADDR_WIDTH-1:0] r_sramAddr;
  logic [3:0]                 r_beN;
  logic                       r_ceN;
  logic                       r_oeN;
  logic                       r_weN;
  logic                       r_dataOe;
  logic [31:0]                r_dataOut;
  logic [31:0]                r_dataRd;
  logic [31:0]                r_dataRd2;

  logic [SRAM_ADDR_WIDTH-1:0] w_reqAddr;
  logic [SRAM_ADDR_WIDTH-1:0] w_addrNext;
  logic                       w_lastWait;
  logic                       w_unused;

  assign w_reqAddr  = bus.bus_address[SRAM_ADDR_WIDTH+1:2];
  assign w_addrNext = r_addr + 1'b1;
  assign w_lastWait = (r_waitCnt == LAST_WAIT);
  assign w_unused   = ^{bus.bus_address[31:SRAM_ADDR_WIDTH+2], bus.bus_address[1:0]};

  // The master is stalled from the request cycle until the DONE cycle.
  assign bus.bus_stall = ((r_state == IDLE) && (bus.bus_read || bus.bus_write)) ||
                         ((r_state != IDLE) && (r_state != DONE));

  assign bus.bus_data_rd   = r_dataRd;
  assign bus.bus_data_rd_2 = r_dataRd2;
  assign sram_address      = r_sramAddr;
  assign sram_be_n         = r_beN;
  assign sram_ce_n         = r_ceN;
  assign sram_oe_n         = r_oeN;
  assign sram_we_n         = r_weN;
  assign sram_data         = r_dataOe ? r_dataOut : 32'hzzzz_zzzz;

  // Access sequencer: strobes for the next state are set on the transition
  // into it, so each state's pin levels are visible for the whole state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_waitCnt  <= '0;
      r_addr     <= '0;
      r_sramAddr <= '0;
      r_beN      <= 4'b1111;
      r_ceN      <= 1'b1;
      r_oeN      <= 1'b1;
      r_weN      <= 1'b1;
      r_dataOe   <= 1'b0;
      r_dataOut  <= '0;
      r_dataRd   <= '0;
      r_dataRd2  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_waitCnt <= '0;
          if (bus.bus_write && (bus.bus_mask != 4'b0000)) begin
            r_addr     <= w_reqAddr;
            r_sramAddr <= w_reqAddr;
            r_beN      <= ~bus.bus_mask;
            r_dataOut  <= bus.bus_data_wr;
            r_dataOe   <= 1'b1;
            r_ceN      <= 1'b0;
            r_weN      <= 1'b0;
            r_oeN      <= 1'b1;
            r_state    <= WR;
          end else if (bus.bus_write) begin
            r_state <= DONE;
          end else if (bus.bus_read) begin
            r_addr     <= w_reqAddr;
            r_sramAddr <= w_reqAddr;
            r_beN      <= 4'b0000;
            r_ceN      <= 1'b0;
            r_oeN      <= 1'b0;
            r_state    <= RD0;
          end
        end
        RD0: begin
          if (w_lastWait) begin
            r_dataRd   <= sram_data;
            r_sramAddr <= w_addrNext;
            r_waitCnt  <= '0;
            r_state    <= RD1;
          end else begin
            r_waitCnt <= r_waitCnt + 4'd1;
          end
        end
        RD1: begin
          if (w_lastWait) begin
            r_dataRd2 <= sram_data;
            r_ceN     <= 1'b1;
            r_oeN     <= 1'b1;
            r_beN     <= 4'b1111;
            r_waitCnt <= '0;
            r_state   <= DONE;
          end else begin
            r_waitCnt <= r_waitCnt + 4'd1;
          end
        end
        WR: begin
          if (w_lastWait) begin
            r_weN     <= 1'b1;
            r_ceN     <= 1'b1;
            r_waitCnt <= '0;
            r_state   <= WR_REC;
          end else begin
            r_waitCnt <= r_waitCnt + 4'd1;
          end
        end
        WR_REC: begin
          r_dataOe <= 1'b0;
          r_beN    <= 4'b1111;
          r_state  <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Testbench for sram_controller: two instances (WAIT_CYCLES 1 and 3), each
// attached to its own behavioural SRAM chip, checked against a word-level
// reference memory and latency formulas.
module tb_sram_controller;

  localparam int AW    = 20;
  localparam int DEPTH = 1 << AW;

  int waitOf [2] = '{1, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] busAddress;
  logic [31:0] busDataWr;
  logic [3:0]  busMask;
  logic [1:0]  rdReq;
  logic [1:0]  wrReq;

  sram_controller_if busIf0 ();
  sram_controller_if busIf1 ();

  assign busIf0.bus_address = busAddress;
  assign busIf0.bus_data_wr = busDataWr;
  assign busIf0.bus_mask    = busMask;
  assign busIf0.bus_read    = rdReq[0];
  assign busIf0.bus_write   = wrReq[0];
  assign busIf1.bus_address = busAddress;
  assign busIf1.bus_data_wr = busDataWr;
  assign busIf1.bus_mask    = busMask;
  assign busIf1.bus_read    = rdReq[1];
  assign busIf1.bus_write   = wrReq[1];

  wire  [31:0]   sramData0;
  wire  [31:0]   sramData1;
  logic [AW-1:0] sramAddr [2];
  logic [3:0]    beN [2];
  logic [1:0]    ceN;
  logic [1:0]    oeN;
  logic [1:0]    weN;
  logic [1:0]    stall;
  logic [1:0]    dutDrive;
  logic [31:0]   rdData [2];
  logic [31:0]   rdData2 [2];
  logic [31:0]   busD [2];

  sram_controller #(.WAIT_CYCLES(1), .SRAM_ADDR_WIDTH(AW)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(busIf0.slave),
    .sram_address(sramAddr[0]), .sram_data(sramData0), .sram_be_n(beN[0]),
    .sram_ce_n(ceN[0]), .sram_oe_n(oeN[0]), .sram_we_n(weN[0])
  );

  sram_controller #(.WAIT_CYCLES(3), .SRAM_ADDR_WIDTH(AW)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(busIf1.slave),
    .sram_address(sramAddr[1]), .sram_data(sramData1), .sram_be_n(beN[1]),
    .sram_ce_n(ceN[1]), .sram_oe_n(oeN[1]), .sram_we_n(weN[1])
  );

  assign stall[0]    = busIf0.bus_stall;
  assign stall[1]    = busIf1.bus_stall;
  assign rdData[0]   = busIf0.bus_data_rd;
  assign rdData[1]   = busIf1.bus_data_rd;
  assign rdData2[0]  = busIf0.bus_data_rd_2;
  assign rdData2[1]  = busIf1.bus_data_rd_2;
  assign dutDrive[0] = dut0.r_dataOe;
  assign dutDrive[1] = dut1.r_dataOe;
  assign busD[0]     = sramData0;
  assign busD[1]     = sramData1;

  // Behavioural asynchronous SRAM chips plus a backdoor preload port.
  logic [31:0]   mem [2][DEPTH];
  logic          bdEn;
  int            bdK;
  logic [AW-1:0] bdAddr;
  logic [31:0]   bdData;

  assign sramData0 = (!ceN[0] && !oeN[0]) ? mem[0][sramAddr[0]] : 32'hzzzz_zzzz;
  assign sramData1 = (!ceN[1] && !oeN[1]) ? mem[1][sramAddr[1]] : 32'hzzzz_zzzz;

  // Chip array update: backdoor preload, and byte writes while ce_n/we_n are low.
  always @(posedge clk) begin
    if (bdEn) mem[bdK][bdAddr] <= bdData;
    for (int k = 0; k < 2; k++) begin
      if (!ceN[k] && !weN[k]) begin
        for (int b = 0; b < 4; b++) begin
          if (!beN[k][b]) mem[k][sramAddr[k]][8*b +: 8] <= busD[k][8*b +: 8];
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] refMem [int];

  function automatic logic [31:0] refRead(input int k, input logic [AW-1:0] a);
    int key = (k << AW) | int'(a);
    return refMem.exists(key) ? refMem[key] : 32'h0;
  endfunction

  function automatic void refWrite(input int k, input logic [AW-1:0] a,
                                   input logic [31:0] d, input logic [3:0] m);
    int key = (k << AW) | int'(a);
    logic [31:0] w = refRead(k, a);
    for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    refMem[key] = w;
  endfunction

  task automatic applyStimulus(input int k, input logic [AW-1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bdEn = 1'b1; bdK = k; bdAddr = a; bdData = d;
    @(posedge clk); #1;
    bdEn = 1'b0;
    refMem[(k << AW) | int'(a)] = d;
  endtask

  // One bus transaction; returns stalled cycles, we_n-low cycles, be_n seen
  // while writing, last address seen while oe_n low, and strobe conflicts.
  task automatic doAccess(input int k, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] mask, output int stallCycles,
                          output int weCycles, output logic [3:0] beSeen,
                          output logic [AW-1:0] lastRdAddr, output int conflicts);
    @(posedge clk); #1;
    busAddress = addr; busDataWr = data; busMask = mask;
    rdReq[k] = rd; wrReq[k] = wr;
    stallCycles = 0; weCycles = 0; beSeen = 4'hf; lastRdAddr = '0; conflicts = 0;
    #1;
    while (stall[k] && stallCycles < 200) begin
      stallCycles++;
      if (!weN[k]) begin weCycles++; beSeen = beN[k]; end
      if (!oeN[k]) lastRdAddr = sramAddr[k];
      if (!oeN[k] && (!weN[k] || dutDrive[k])) conflicts++;
      @(posedge clk); #2;
    end
    checks++;
    if (stallCycles >= 200) begin
      errors++;
      $display("[TB] FAIL access_timeout inst=%0d stall still high after %0d cycles", k, stallCycles);
    end
    rdReq[k] = 1'b0; wrReq[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({ceN[k], oeN[k], weN[k], beN[k], sramAddr[k], rdData[k], rdData2[k], stall[k], dutDrive[k]} !==
          {3'b111, 4'b1111, {AW{1'b0}}, 32'h0, 32'h0, 1'b0, 1'b0}) begin
        errors++;
        $display("[TB] FAIL reset_state inst=%0d got ce=%b oe=%b we=%b be=%b addr=%h rd=%h rd2=%h stall=%b drv=%b want ce/oe/we=1 be=1111 addr=0 rd=0 rd2=0 stall=0 drv=0",
                 k, ceN[k], oeN[k], weN[k], beN[k], sramAddr[k], rdData[k], rdData2[k], stall[k], dutDrive[k]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    int st, we, cf; logic [3:0] be; logic [AW-1:0] la;
    applyStimulus(0, 20'h40, 32'h55AA_33CC);
    @(posedge clk); #1;
    busAddress = 32'h0000_0100; busDataWr = $urandom; busMask = 4'hf; wrReq[0] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (weN[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL midwr_in_wr we_n=%b want 0", weN[0]);
    end
    rst_n = 1'b0; wrReq[0] = 1'b0;
    #1;
    checks++;
    if ({weN[0], ceN[0], dutDrive[0], stall[0]} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL midwr_reset we=%b ce=%b drv=%b stall=%b want we=1 ce=1 drv=0 stall=0",
               weN[0], ceN[0], dutDrive[0], stall[0]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    doAccess(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, st, we, be, la, cf);
    checks++;
    if (st !== 1 + 2 * waitOf[0] || rdData[0] !== refRead(0, 20'h40)) begin
      errors++;
      $display("[TB] FAIL midwr_after stall=%0d rd=%h want stall=%0d rd=%h",
               st, rdData[0], 1 + 2 * waitOf[0], refRead(0, 20'h40));
    end
  endtask

  task automatic test_read_basic();
    int st, we, cf; logic [3:0] be; logic [AW-1:0] la;
    applyStimulus(0, 20'h100, 32'hDEAD_BEEF);
    applyStimulus(0, 20'h101, 32'h1234_5678);
    doAccess(0, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'h0, st, we, be, la, cf);
    checks++;
    if (st !== 3) begin errors++; $display("[TB] FAIL read_stall got %0d want 3", st); end
    checks++;
    if (rdData[0] !== 32'hDEAD_BEEF || rdData2[0] !== 32'h1234_5678) begin
      errors++;
      $display("[TB] FAIL read_data got %h/%h want deadbeef/12345678", rdData[0], rdData2[0]);
    end
    checks++;
    if (cf !== 0) begin errors++; $display("[TB] FAIL read_conflict got %0d want 0", cf); end
  endtask

  task automatic test_masked_write();
    int st, we, cf; logic [3:0] be; logic [AW-1:0] la;
    applyStimulus(0, 20'h2, 32'h1122_3344);
    doAccess(0, 1'b0, 1'b1, 32'h0000_0008, 32'hAABB_CCDD, 4'b0101, st, we, be, la, cf);
    refWrite(0, 20'h2, 32'hAABB_CCDD, 4'b0101);
    checks++;
    if (st !== 3 || we !== waitOf[0]) begin
      errors++; $display("[TB] FAIL mwr_timing stall=%0d we_cycles=%0d want 3/1", st, we);
    end
    checks++;
    if (be !== 4'b1010) begin errors++; $display("[TB] FAIL mwr_be_n got %b want 1010", be); end
    doAccess(0, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 4'h0, st, we, be, la, cf);
    checks++;
    if (rdData[0] !== refRead(0, 20'h2)) begin
      errors++; $display("[TB] FAIL mwr_readback got %h want %h", rdData[0], refRead(0, 20'h2));
    end
  endtask

  task automatic test_wrap();
    int st, we, cf; logic [3:0] be; logic [AW-1:0] la;
    applyStimulus(0, 20'hFFFFF, $urandom);
    applyStimulus(0, 20'h00000, $urandom);
    doAccess(0, 1'b1, 1'b0, 32'h003F_FFFC, 32'h0, 4'h0, st, we, be, la, cf);
    checks++;
    if (la !== 20'h00000) begin errors++; $display("[TB] FAIL wrap_addr got %h want 00000", la); end
    checks++;
    if (rdData[0] !== refRead(0, 20'hFFFFF) || rdData2[0] !== refRead(0, 20'h0)) begin
      errors++;
      $display("[TB] FAIL wrap_data got %h/%h want %h/%h", rdData[0], rdData2[0],
               refRead(0, 20'hFFFFF), refRead(0, 20'h0));
    end
  endtask

  task automatic test_priority();
    int st, we, cf; logic [3:0] be; logic [AW-1:0] la;
    logic [31:0] prevRd, d;
    applyStimulus(0, 20'h20, $urandom);
    applyStimulus(0, 20'h21, $urandom);
    doAccess(0, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'h0, st, we, be, la, cf);
    prevRd = refRead(0, 20'h20);
    d = $urandom;
    doAccess(0, 1'b1, 1'b1, 32'h0000_0080, d, 4'hf, st, we, be, la, cf);
    refWrite(0, 20'h20, d, 4'hf);
    checks++;
    if (st !== waitOf[0] + 2 || we !== waitOf[0] || rdData[0] !== prevRd) begin
      errors++;
      $display("[TB] FAIL both_req stall=%0d we_cycles=%0d rd=%h want %0d/%0d/%h",
               st, we, rdData[0], waitOf[0] + 2, waitOf[0], prevRd);
    end
    doAccess(0, 1'b0, 1'b1, 32'h0000_0080, ~d, 4'h0, st, we, be, la, cf);
    checks++;
    if (st !== 1 || we !== 0) begin
      errors++; $display("[TB] FAIL zero_mask stall=%0d we_cycles=%0d want 1/0", st, we);
    end
    doAccess(0, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'h0, st, we, be, la, cf);
    checks++;
    if (rdData[0] !== refRead(0, 20'h20)) begin
      errors++; $display("[TB] FAIL prio_readback got %h want %h", rdData[0], refRead(0, 20'h20));
    end
  endtask

  task automatic test_back_to_back();
    int st, we, cf; logic [3:0] be; logic [AW-1:0] la;
    logic [31:0] d = $urandom;
    applyStimulus(1, 20'h30, $urandom);
    applyStimulus(1, 20'h31, $urandom);
    doAccess(1, 1'b0, 1'b1, 32'h0000_00C0, d, 4'hf, st, we, be, la, cf);
    refWrite(1, 20'h30, d, 4'hf);
    checks++;
    if (st !== 5 || we !== 3 || cf !== 0) begin
      errors++; $display("[TB] FAIL b2b_write stall=%0d we_cycles=%0d conflicts=%0d want 5/3/0", st, we, cf);
    end
    doAccess(1, 1'b1, 1'b0, 32'h0000_00C0, 32'h0, 4'h0, st, we, be, la, cf);
    checks++;
    if (st !== 7 || cf !== 0) begin
      errors++; $display("[TB] FAIL b2b_read_stall stall=%0d conflicts=%0d want 7/0", st, cf);
    end
    checks++;
    if (rdData[1] !== refRead(1, 20'h30) || rdData2[1] !== refRead(1, 20'h31)) begin
      errors++;
      $display("[TB] FAIL b2b_read_data got %h/%h want %h/%h", rdData[1], rdData2[1],
               refRead(1, 20'h30), refRead(1, 20'h31));
    end
  endtask

  task automatic test_random();
    int st, we, cf, op, base, expSt;
    logic [3:0] be, m; logic [AW-1:0] la, a; logic [31:0] d, ba, lastRd, lastRd2;
    for (int k = 0; k < 2; k++) begin
      base = $urandom_range(0, DEPTH - 20);
      for (int i = 0; i < 17; i++) applyStimulus(k, AW'(base + i), $urandom);
      lastRd = rdData[k]; lastRd2 = rdData2[k];
      for (int i = 0; i < 12; i++) begin
        op = $urandom_range(0, 1);
        a  = AW'(base + $urandom_range(0, 15));
        ba = {10'($urandom), a, 2'($urandom)};
        d  = $urandom;
        m  = 4'($urandom);
        if (op == 0) begin
          doAccess(k, 1'b1, 1'b0, ba, d, m, st, we, be, la, cf);
          lastRd = refRead(k, a); lastRd2 = refRead(k, a + 1'b1);
          expSt = 1 + 2 * waitOf[k];
        end else begin
          doAccess(k, 1'b0, 1'b1, ba, d, m, st, we, be, la, cf);
          refWrite(k, a, d, m);
          expSt = (m != 4'h0) ? waitOf[k] + 2 : 1;
        end
        checks++;
        if (st !== expSt || cf !== 0) begin
          errors++;
          $display("[TB] FAIL rand_stall inst=%0d op=%0d mask=%b stall=%0d conflicts=%0d want %0d/0",
                   k, op, m, st, cf, expSt);
        end
        checks++;
        if (rdData[k] !== lastRd || rdData2[k] !== lastRd2) begin
          errors++;
          $display("[TB] FAIL rand_data inst=%0d op=%0d addr=%h got %h/%h want %h/%h",
                   k, op, a, rdData[k], rdData2[k], lastRd, lastRd2);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; rdReq = 2'b00; wrReq = 2'b00;
    busAddress = '0; busDataWr = '0; busMask = '0;
    bdEn = 1'b0; bdK = 0; bdAddr = '0; bdData = '0;
    test_reset();
    test_reset_mid_write();
    test_read_basic();
    test_masked_write();
    test_wrap();
    test_priority();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
